// File: rtl/verificador_pin_pkg.sv
// Shared constants and state encoding for the PIN-entry checker.
package verificador_pin_pkg;

    localparam int DIG_W = 4;
    localparam logic [DIG_W-1:0] BORRAR     = 4'hA;
    localparam logic [DIG_W-1:0] MAX_DIGITO = 4'd9;

    typedef enum logic [1:0] {
        ESPERA_TARJETA = 2'd0,
        RECIBIENDO     = 2'd1,
        COMPARANDO     = 2'd2,
        BLOQUEADO      = 2'd3
    } estado_t;

endpackage

// File: rtl/temporizador_inactividad.sv
// Inactivity down-counter: reload sets it to TIMEOUT_CICLOS-1, it counts one
// per enabled edge and saturates at zero, which flags expiry. Expiry is seen on
// the TIMEOUT_CICLOS-th consecutive enabled edge without a reload.
module temporizador_inactividad #(
    parameter int TIMEOUT_CICLOS = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic recargar,
    input  logic contar,
    output logic expirado
);

    localparam int TW = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [TW-1:0] RECARGA = TW'(TIMEOUT_CICLOS - 1);

    logic [TW-1:0] cuenta_q, cuenta_d;

    // Next count: reload has priority, otherwise count down while enabled.
    always_comb begin
        cuenta_d = cuenta_q;
        if (recargar)
            cuenta_d = RECARGA;
        else if (contar && cuenta_q != '0)
            cuenta_d = cuenta_q - 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cuenta_q <= RECARGA;
        else        cuenta_q <= cuenta_d;
    end

    assign expirado = (cuenta_q == '0);

endmodule

// File: rtl/verificador_pin.sv
// PIN-entry checker: collects N_DIGITOS BCD digits, compares against the
// stored PIN, counts failures with warning and sticky lockout, supports an
// erase key and an inactivity timeout. All outputs come straight from flops.
module verificador_pin
    import verificador_pin_pkg::*;
#(
    parameter int N_DIGITOS      = 4,
    parameter int MAX_INTENTOS   = 3,
    parameter int TIMEOUT_CICLOS = 1000
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  tarjeta_recibida,
    input  logic                                  digito_stb,
    input  logic [DIG_W-1:0]                      digito,
    input  logic [DIG_W*N_DIGITOS-1:0]            pin_correcto,
    output logic                                  pin_incorrecto,
    output logic                                  advertencia,
    output logic                                  bloqueo,
    output logic                                  fin,
    output logic                                  tiempo_agotado,
    output logic [$clog2(N_DIGITOS+1)-1:0]        digitos_ingresados,
    output logic [$clog2(MAX_INTENTOS+1)-1:0]     intentos_fallidos
);

    localparam int DCW = $clog2(N_DIGITOS + 1);
    localparam int ICW = $clog2(MAX_INTENTOS + 1);
    localparam int EW  = DIG_W * N_DIGITOS;
    localparam logic [DCW-1:0] ULTIMO_DIG = DCW'(N_DIGITOS - 1);
    localparam logic [ICW-1:0] ULTIMO_INT = ICW'(MAX_INTENTOS - 1);

    estado_t        estado_q, estado_d;
    logic [EW-1:0]  entrada_q, entrada_d;
    logic [DCW-1:0] digitos_q, digitos_d;
    logic [ICW-1:0] intentos_q, intentos_d;
    logic           fin_q, fin_d;
    logic           pin_inc_q, pin_inc_d;
    logic           agotado_q, agotado_d;
    logic           bloqueo_q, bloqueo_d;
    logic           advert_q, advert_d;
    logic           recargar, expirado, en_recibiendo;
    logic           es_digito, es_borrar;

    assign en_recibiendo = (estado_q == RECIBIENDO);
    assign es_digito     = digito_stb && (digito <= MAX_DIGITO);
    assign es_borrar     = digito_stb && (digito == BORRAR);

    temporizador_inactividad #(
        .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
    ) u_temporizador (
        .clk      (clk),
        .reset    (reset),
        .recargar (recargar),
        .contar   (en_recibiendo),
        .expirado (expirado)
    );

    // Next-state, entry register, attempt counter and registered outputs.
    always_comb begin
        estado_d   = estado_q;
        entrada_d  = entrada_q;
        digitos_d  = digitos_q;
        intentos_d = intentos_q;
        fin_d      = 1'b0;
        pin_inc_d  = 1'b0;
        agotado_d  = 1'b0;
        recargar   = 1'b0;
        unique case (estado_q)
            ESPERA_TARJETA: begin
                if (tarjeta_recibida) begin
                    estado_d  = RECIBIENDO;
                    entrada_d = '0;
                    digitos_d = '0;
                    recargar  = 1'b1;
                end
            end
            RECIBIENDO: begin
                // An accepted strobe beats expiry on the same edge.
                if (es_digito) begin
                    entrada_d              = entrada_q << DIG_W;
                    entrada_d[DIG_W-1:0]   = digito;
                    digitos_d              = digitos_q + 1'b1;
                    recargar               = 1'b1;
                    if (digitos_q == ULTIMO_DIG) estado_d = COMPARANDO;
                end else if (es_borrar) begin
                    entrada_d = '0;
                    digitos_d = '0;
                    recargar  = 1'b1;
                end else if (expirado) begin
                    // Attempt count is kept so a timeout cannot launder failures.
                    agotado_d = 1'b1;
                    entrada_d = '0;
                    digitos_d = '0;
                    estado_d  = ESPERA_TARJETA;
                end
            end
            COMPARANDO: begin
                entrada_d = '0;
                digitos_d = '0;
                if (entrada_q == pin_correcto) begin
                    fin_d      = 1'b1;
                    intentos_d = '0;
                    estado_d   = ESPERA_TARJETA;
                end else begin
                    pin_inc_d  = 1'b1;
                    intentos_d = intentos_q + 1'b1;
                    if (intentos_q == ULTIMO_INT) begin
                        estado_d = BLOQUEADO;
                    end else begin
                        estado_d = RECIBIENDO;
                        recargar = 1'b1;
                    end
                end
            end
            BLOQUEADO: ;
            default:   estado_d = ESPERA_TARJETA;
        endcase
        bloqueo_d = (estado_d == BLOQUEADO);
        advert_d  = (intentos_d == ULTIMO_INT) && !bloqueo_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q   <= ESPERA_TARJETA;
            entrada_q  <= '0;
            digitos_q  <= '0;
            intentos_q <= '0;
            fin_q      <= 1'b0;
            pin_inc_q  <= 1'b0;
            agotado_q  <= 1'b0;
            bloqueo_q  <= 1'b0;
            advert_q   <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            entrada_q  <= entrada_d;
            digitos_q  <= digitos_d;
            intentos_q <= intentos_d;
            fin_q      <= fin_d;
            pin_inc_q  <= pin_inc_d;
            agotado_q  <= agotado_d;
            bloqueo_q  <= bloqueo_d;
            advert_q   <= advert_d;
        end
    end

    assign pin_incorrecto     = pin_inc_q;
    assign advertencia        = advert_q;
    assign bloqueo            = bloqueo_q;
    assign fin                = fin_q;
    assign tiempo_agotado     = agotado_q;
    assign digitos_ingresados = digitos_q;
    assign intentos_fallidos  = intentos_q;

endmodule

// File: tb/tb_verificador_pin.sv
// Bench for verificador_pin: a 4-digit and a 6-digit instance share stimulus;
// a behavioural model per instance is checked every cycle, plus literal checks.
module tb_verificador_pin;

    localparam int T    = 16;
    localparam int MAXI = 3;
    localparam int S_ESP = 0, S_REC = 1, S_CMP = 2, S_BLQ = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tarjeta = 1'b0;
    logic        stb = 1'b0;
    logic [3:0]  dig = 4'd0;
    logic [15:0] pin4 = 16'h1234;
    logic [23:0] pin6 = 24'h987654;
    logic        chk_en = 1'b0;

    logic       a_pi, a_adv, a_blq, a_fin, a_to;
    logic [2:0] a_dig;
    logic [1:0] a_int;
    logic       b_pi, b_adv, b_blq, b_fin, b_to;
    logic [2:0] b_dig;
    logic [1:0] b_int;

    int n_tests = 0;
    int n_fail  = 0;

    // model state, index 0 = 4-digit instance, 1 = 6-digit instance
    int m_st[2], m_n[2], m_int[2], m_idle[2];
    int m_d[2][8];
    bit m_fin[2], m_pi[2], m_to[2];

    verificador_pin #(.N_DIGITOS(4), .MAX_INTENTOS(MAXI), .TIMEOUT_CICLOS(T)) dut4 (
        .clk(clk), .reset(rst_n), .tarjeta_recibida(tarjeta), .digito_stb(stb),
        .digito(dig), .pin_correcto(pin4), .pin_incorrecto(a_pi), .advertencia(a_adv),
        .bloqueo(a_blq), .fin(a_fin), .tiempo_agotado(a_to),
        .digitos_ingresados(a_dig), .intentos_fallidos(a_int));

    verificador_pin #(.N_DIGITOS(6), .MAX_INTENTOS(MAXI), .TIMEOUT_CICLOS(T)) dut6 (
        .clk(clk), .reset(rst_n), .tarjeta_recibida(tarjeta), .digito_stb(stb),
        .digito(dig), .pin_correcto(pin6), .pin_incorrecto(b_pi), .advertencia(b_adv),
        .bloqueo(b_blq), .fin(b_fin), .tiempo_agotado(b_to),
        .digitos_ingresados(b_dig), .intentos_fallidos(b_int));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = S_ESP; m_n[i] = 0; m_int[i] = 0; m_idle[i] = 0;
            m_fin[i] = 0; m_pi[i] = 0; m_to[i] = 0;
        end
    endtask

    task automatic m_step(input int i, input int nd, input logic [31:0] pin);
        logic [31:0] v;
        m_fin[i] = 0; m_pi[i] = 0; m_to[i] = 0;
        case (m_st[i])
            S_ESP: if (tarjeta) begin m_st[i] = S_REC; m_n[i] = 0; m_idle[i] = 0; end
            S_REC: begin
                if (stb && dig <= 4'd9) begin
                    m_d[i][m_n[i]] = int'(dig);
                    m_n[i]++;
                    m_idle[i] = 0;
                    if (m_n[i] == nd) m_st[i] = S_CMP;
                end else if (stb && dig == 4'hA) begin
                    m_n[i] = 0; m_idle[i] = 0;
                end else begin
                    m_idle[i]++;
                    if (m_idle[i] == T) begin m_to[i] = 1; m_n[i] = 0; m_st[i] = S_ESP; end
                end
            end
            S_CMP: begin
                v = 0;
                for (int j = 0; j < nd; j++) v = (v << 4) | 32'(m_d[i][j]);
                m_n[i] = 0;
                if (v == pin) begin
                    m_fin[i] = 1; m_int[i] = 0; m_st[i] = S_ESP;
                end else begin
                    m_pi[i] = 1; m_int[i]++; m_idle[i] = 0;
                    m_st[i] = (m_int[i] == MAXI) ? S_BLQ : S_REC;
                end
            end
            default: ;
        endcase
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_reset();
        else begin
            m_step(0, 4, {16'd0, pin4});
            m_step(1, 6, {8'd0, pin6});
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("fin4", a_fin, m_fin[0]);
            chk("pin_incorrecto4", a_pi, m_pi[0]);
            chk("tiempo_agotado4", a_to, m_to[0]);
            chk("bloqueo4", a_blq, m_st[0] == S_BLQ);
            chk("advertencia4", a_adv, m_int[0] == MAXI-1 && m_st[0] != S_BLQ);
            chk("digitos4", a_dig, m_n[0]);
            chk("intentos4", a_int, m_int[0]);
            chk("fin6", b_fin, m_fin[1]);
            chk("pin_incorrecto6", b_pi, m_pi[1]);
            chk("tiempo_agotado6", b_to, m_to[1]);
            chk("bloqueo6", b_blq, m_st[1] == S_BLQ);
            chk("advertencia6", b_adv, m_int[1] == MAXI-1 && m_st[1] != S_BLQ);
            chk("digitos6", b_dig, m_n[1]);
            chk("intentos6", b_int, m_int[1]);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask
    task automatic key(input logic [3:0] d);
        stb = 1'b1; dig = d; cyc(1); stb = 1'b0;
    endtask
    task automatic card();
        tarjeta = 1'b1; cyc(1); tarjeta = 1'b0;
    endtask
    task automatic keys4(input logic [15:0] v);
        for (int j = 3; j >= 0; j--) key(v[4*j +: 4]);
    endtask
    task automatic do_reset();
        rst_n = 1'b0; cyc(2); rst_n = 1'b1;
    endtask

    initial begin
        cyc(3);
        chk("reset_outs4", {a_pi, a_adv, a_blq, a_fin, a_to, a_dig, a_int}, 0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        cyc(1);

        // correct PIN
        card(); key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        chk("s1_fin_compare_cycle", a_fin, 0);
        chk("s1_digitos_full", a_dig, 4);
        cyc(1);
        chk("s1_fin", a_fin, 1);
        chk("s1_pin_incorrecto", a_pi, 0);
        chk("s1_intentos", a_int, 0);
        cyc(1);
        chk("s1_fin_one_cycle", a_fin, 0);

        // three wrong PINs -> lockout
        card(); keys4(16'h1235); cyc(1);
        chk("s2_pi1", a_pi, 1);
        chk("s2_int1", a_int, 1);
        chk("s2_adv1", a_adv, 0);
        keys4(16'h1235); cyc(1);
        chk("s2_int2", a_int, 2);
        chk("s2_adv2", a_adv, 1);
        keys4(16'h1235); cyc(1);
        chk("s2_blq", a_blq, 1);
        chk("s2_adv_blq", a_adv, 0);
        chk("s2_int3", a_int, 3);
        card(); keys4(16'h1234); cyc(2);
        chk("s2_blq_sticky", a_blq, 1);
        chk("s2_no_fin", a_fin, 0);
        chk("s2_digitos_blq", a_dig, 0);

        // erase key
        do_reset();
        card(); key(4'd1); key(4'd2); key(4'hA);
        chk("s3_borrar", a_dig, 0);
        keys4(16'h1234); cyc(1);
        chk("s3_fin", a_fin, 1);
        chk("s3_int", a_int, 0);

        // timeout with one prior failure
        cyc(1);
        card(); keys4(16'h1235); cyc(1);
        chk("s4_int_before", a_int, 1);
        key(4'd1); key(4'd2);
        cyc(T-1);
        chk("s4_no_to_yet", a_to, 0);
        chk("s4_dig_held", a_dig, 2);
        cyc(1);
        chk("s4_to", a_to, 1);
        chk("s4_int_kept", a_int, 1);
        chk("s4_dig_clear", a_dig, 0);

        // ignored codes interleaved
        cyc(1);
        card(); key(4'd1); key(4'hC);
        chk("s5_dig_after_C", a_dig, 1);
        key(4'd2); key(4'hF); key(4'd3);
        chk("s5_dig_after_F", a_dig, 3);
        key(4'd4); cyc(1);
        chk("s5_fin", a_fin, 1);

        // 6-digit PIN
        do_reset();
        card(); key(4'd9); key(4'd8); key(4'd7); key(4'd6); key(4'd5); key(4'd4);
        cyc(1);
        chk("s6_fin6", b_fin, 1);
        chk("s6_int6", b_int, 0);

        // asynchronous reset mid-entry
        do_reset();
        card(); keys4(16'h0000); cyc(1); keys4(16'h0000); cyc(1);
        chk("s7_int2", a_int, 2);
        key(4'd1); key(4'd2);
        rst_n = 1'b0; #1;
        chk("s7_async_reset4", {a_pi, a_adv, a_blq, a_fin, a_to, a_dig, a_int}, 0);
        chk("s7_async_reset6", {b_pi, b_adv, b_blq, b_fin, b_to, b_dig, b_int}, 0);
        cyc(2);
        rst_n = 1'b1;

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            int r;
            bit dense;
            dense   = ((c / 300) % 2) == 0;
            rst_n   = (c % 600) > 1;
            tarjeta = ($urandom_range(0, 7) == 0);
            stb     = dense ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 24) == 0);
            r = $urandom_range(0, 9);
            if (r < 6)      dig = (m_n[0] < 4) ? pin4[4*(3-m_n[0]) +: 4] : 4'd0;
            else if (r < 7) dig = 4'hA;
            else if (r < 8) dig = 4'($urandom_range(11, 15));
            else            dig = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 199) == 0)
                pin4 = ($urandom_range(0, 1) == 1) ? 16'h1234 : 16'h5678;
            cyc(1);
        end
        stb = 1'b0; tarjeta = 1'b0; rst_n = 1'b1;
        cyc(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
